// File: rtl/seq_pkg.sv
// ---------------------------------------------------------------------------
// seq_pkg
//   Shared definitions for the address sequence controller:
//     - op_e        : opcode encoding carried on i_op_mode
//     - MODE_*      : address-generator mode codes driven on o_mode
//     - DEPTH_*     : channel-depth codes driven on o_depth (8/16/32)
//     - LOAD_LAST   : final pixel index of an image load (2048 beats)
//     - ORIGIN_MAX  : largest legal window row/column coordinate
//     - sweep_last(): terminal counter value of a display/conv sweep
// ---------------------------------------------------------------------------
package seq_pkg;

   typedef enum logic [3:0] {
      OP_LOAD       = 4'd0,
      OP_RIGHT      = 4'd1,
      OP_LEFT       = 4'd2,
      OP_UP         = 4'd3,
      OP_DOWN       = 4'd4,
      OP_SCALE_DOWN = 4'd5,
      OP_SCALE_UP   = 4'd6,
      OP_DISPLAY    = 4'd7,
      OP_CONV       = 4'd8
   } op_e;

   localparam logic [1:0] MODE_LOAD    = 2'd0;
   localparam logic [1:0] MODE_DISPLAY = 2'd1;
   localparam logic [1:0] MODE_CONV    = 2'd2;

   localparam logic [1:0] DEPTH_8  = 2'd0;
   localparam logic [1:0] DEPTH_16 = 2'd1;
   localparam logic [1:0] DEPTH_32 = 2'd2;

   localparam logic [10:0] LOAD_LAST  = 11'd2047;
   localparam logic [2:0]  ORIGIN_MAX = 3'd6;

   // Display touches 4 pixels per channel, conv touches 16 pixels per
   // channel; the returned value is the last index of that sweep.
   function automatic logic [10:0] sweep_last(input logic [1:0] mode,
                                              input logic [1:0] depth);
      logic [10:0] channels;
      case (depth)
         DEPTH_8:  channels = 11'd8;
         DEPTH_16: channels = 11'd16;
         default:  channels = 11'd32;
      endcase
      if (mode == MODE_CONV)
         return (channels << 4) - 11'd1;
      else
         return (channels << 2) - 11'd1;
   endfunction

endpackage

// File: rtl/seq_lat_pipe.sv
// ---------------------------------------------------------------------------
// seq_lat_pipe
//   DEPTH-stage shift register that delays the final-access marker of a
//   sweep by the memory read latency, so the controller knows when the last
//   read data has come back.
//   Ports:
//     i_clk   clock
//     i_rst   asynchronous active-high reset (clears every stage)
//     i_last  final access of a sweep issued this cycle
//     o_fire  i_last delayed by DEPTH cycles
// ---------------------------------------------------------------------------
module seq_lat_pipe #(
   parameter int DEPTH = 1
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_last,
   output logic o_fire
);

   logic [DEPTH-1:0] stage_reg;
   logic [DEPTH-1:0] stage_next;

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
         assign stage_next[gi] = i_last;
      end else begin : g_body
         assign stage_next[gi] = stage_reg[gi-1];
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         stage_reg <= '0;
      else
         stage_reg <= stage_next;
   end

   assign o_fire = stage_reg[DEPTH-1];

endmodule

// File: rtl/addr_seq_ctrl.sv
// ---------------------------------------------------------------------------
// addr_seq_ctrl
//   Opcode-driven controller that sequences an external address generator:
//   image load (2048 pixel beats), window shifts, channel-depth scaling,
//   display sweeps (4*depth reads) and conv sweeps (16*depth reads), each
//   finishing with a single-cycle o_done.
//   Build option: define SEQ_DEPTH_SCALE_EN to enable scale-down/scale-up;
//   otherwise depth is fixed at 32 and opcodes 5/6 only pulse o_done.
//   Ports:
//     i_clk, i_rst          clock, asynchronous active-high reset
//     i_op_valid/i_op_mode  opcode handshake input (accepted when o_op_ready)
//     o_op_ready            controller idle
//     i_in_valid/o_in_ready pixel beat handshake during load
//     o_counter             sweep index for the address generator
//     o_mode                0 load, 1 display, 2 conv
//     o_origin              window origin {row[2:0], col[2:0]}
//     o_depth               0 = 8, 1 = 16, 2 = 32 channels
//     o_rd_en, o_last       memory access issued / final access of sweep
//     o_done                opcode complete pulse
//   Parameter RD_LAT (1..3): memory read latency waited out after a sweep.
// ---------------------------------------------------------------------------
module addr_seq_ctrl
   import seq_pkg::*;
#(
   parameter int RD_LAT = 1
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_op_valid,
   input  logic [3:0]  i_op_mode,
   output logic        o_op_ready,
   input  logic        i_in_valid,
   output logic        o_in_ready,
   output logic [10:0] o_counter,
   output logic [1:0]  o_mode,
   output logic [5:0]  o_origin,
   output logic [1:0]  o_depth,
   output logic        o_rd_en,
   output logic        o_last,
   output logic        o_done
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_ISSUE,
      ST_DRAIN,
      ST_DONE
   } state_e;

   state_e      state_reg, state_next;
   logic [10:0] counter_reg, counter_next;
   logic [1:0]  mode_reg, mode_next;
   logic [5:0]  origin_reg, origin_next;
   logic [1:0]  depth_cur;
   logic [2:0]  row_cur, col_cur;
   logic [10:0] sweep_limit;
   logic        in_ready, rd_en, last, done;
   logic        drain_fire;

`ifdef SEQ_DEPTH_SCALE_EN
   logic [1:0] depth_reg, depth_next;
   assign depth_cur = depth_reg;
`else
   assign depth_cur = DEPTH_32;
`endif

   assign row_cur     = origin_reg[5:3];
   assign col_cur     = origin_reg[2:0];
   assign sweep_limit = sweep_last(mode_reg, depth_cur);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         state_reg <= ST_IDLE;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next   = state_reg;
      counter_next = counter_reg;
      mode_next    = mode_reg;
      origin_next  = origin_reg;
`ifdef SEQ_DEPTH_SCALE_EN
      depth_next   = depth_reg;
`endif
      in_ready = 1'b0;
      rd_en    = 1'b0;
      last     = 1'b0;
      done     = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            if (i_op_valid) begin
               // Anything not listed (including 9..15) just completes.
               state_next = ST_DONE;
               case (i_op_mode)
                  OP_LOAD: begin
                     state_next   = ST_LOAD;
                     mode_next    = MODE_LOAD;
                     counter_next = '0;
                  end
                  OP_RIGHT: if (col_cur != ORIGIN_MAX) origin_next = {row_cur, col_cur + 3'd1};
                  OP_LEFT:  if (col_cur != 3'd0)       origin_next = {row_cur, col_cur - 3'd1};
                  OP_UP:    if (row_cur != 3'd0)       origin_next = {row_cur - 3'd1, col_cur};
                  OP_DOWN:  if (row_cur != ORIGIN_MAX) origin_next = {row_cur + 3'd1, col_cur};
`ifdef SEQ_DEPTH_SCALE_EN
                  OP_SCALE_DOWN: if (depth_reg != DEPTH_8)  depth_next = depth_reg - 2'd1;
                  OP_SCALE_UP:   if (depth_reg != DEPTH_32) depth_next = depth_reg + 2'd1;
`endif
                  OP_DISPLAY: begin
                     state_next   = ST_ISSUE;
                     mode_next    = MODE_DISPLAY;
                     counter_next = '0;
                  end
                  OP_CONV: begin
                     state_next   = ST_ISSUE;
                     mode_next    = MODE_CONV;
                     counter_next = '0;
                  end
                  default: ;
               endcase
            end
         end

         ST_LOAD: begin
            in_ready = 1'b1;
            if (i_in_valid) begin
               if (counter_reg == LOAD_LAST) begin
                  last       = 1'b1;
                  state_next = ST_DONE;
               end else begin
                  counter_next = counter_reg + 11'd1;
               end
            end
         end

         ST_ISSUE: begin
            rd_en = 1'b1;
            // Counter parks on the terminal value so it reads back as the
            // last index between sweeps.
            if (counter_reg == sweep_limit) begin
               last       = 1'b1;
               state_next = ST_DRAIN;
            end else begin
               counter_next = counter_reg + 11'd1;
            end
         end

         ST_DRAIN: begin
            if (drain_fire)
               state_next = ST_DONE;
         end

         ST_DONE: begin
            done       = 1'b1;
            state_next = ST_IDLE;
         end

         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         counter_reg <= '0;
         mode_reg    <= MODE_LOAD;
         origin_reg  <= '0;
`ifdef SEQ_DEPTH_SCALE_EN
         depth_reg   <= DEPTH_32;
`endif
      end else begin
         counter_reg <= counter_next;
         mode_reg    <= mode_next;
         origin_reg  <= origin_next;
`ifdef SEQ_DEPTH_SCALE_EN
         depth_reg   <= depth_next;
`endif
      end
   end

   // Only the end of a read sweep arms the drain timer; load has no reads
   // in flight.
   seq_lat_pipe #(
      .DEPTH (RD_LAT)
   ) u_lat_pipe (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_last (last && (state_reg == ST_ISSUE)),
      .o_fire (drain_fire)
   );

   assign o_op_ready = (state_reg == ST_IDLE);
   assign o_in_ready = in_ready;
   assign o_rd_en    = rd_en;
   assign o_last     = last;
   assign o_done     = done;
   assign o_counter  = counter_reg;
   assign o_mode     = mode_reg;
   assign o_origin   = origin_reg;
   assign o_depth    = depth_cur;

endmodule

// File: tb/tb_addr_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_addr_seq_ctrl
//   Self-checking bench for addr_seq_ctrl. A transaction-level model keeps
//   the window origin as (row, col), the depth as a channel count and the
//   expected sweep length per opcode; each opcode is observed cycle by cycle
//   and summarised into counts and timings compared against the model.
//   Follows SEQ_DEPTH_SCALE_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_addr_seq_ctrl;

   localparam int RD_LAT = 2;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_op_valid;
   logic [3:0]  i_op_mode;
   logic        o_op_ready;
   logic        i_in_valid;
   logic        o_in_ready;
   logic [10:0] o_counter;
   logic [1:0]  o_mode;
   logic [5:0]  o_origin;
   logic [1:0]  o_depth;
   logic        o_rd_en;
   logic        o_last;
   logic        o_done;

   int checks   = 0;
   int failures = 0;

   // reference model state
   int row = 0, col = 0, ch = 32, exp_mode = 0, exp_counter = 0;

   addr_seq_ctrl #(.RD_LAT(RD_LAT)) dut (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_op_valid (i_op_valid),
      .i_op_mode  (i_op_mode),
      .o_op_ready (o_op_ready),
      .i_in_valid (i_in_valid),
      .o_in_ready (o_in_ready),
      .o_counter  (o_counter),
      .o_mode     (o_mode),
      .o_origin   (o_origin),
      .o_depth    (o_depth),
      .o_rd_en    (o_rd_en),
      .o_last     (o_last),
      .o_done     (o_done)
   );

   always #5 i_clk = ~i_clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic int depth_code(input int channels);
      return (channels == 8) ? 0 : (channels == 16) ? 1 : 2;
   endfunction

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_counter"},  32'(o_counter), 0);
      check_eq({tag, "_mode"},     32'(o_mode), 0);
      check_eq({tag, "_origin"},   32'(o_origin), 0);
      check_eq({tag, "_depth"},    32'(o_depth), 2);
      check_eq({tag, "_rd_en"},    32'(o_rd_en), 0);
      check_eq({tag, "_last"},     32'(o_last), 0);
      check_eq({tag, "_done"},     32'(o_done), 0);
      check_eq({tag, "_in_ready"}, 32'(o_in_ready), 0);
      check_eq({tag, "_op_ready"}, 32'(o_op_ready), 1);
   endtask

   task automatic wait_ready();
      int n = 0;
      while (o_op_ready !== 1'b1 && n < 100) begin
         @(posedge i_clk); #1;
         n++;
      end
      if (n >= 100) check_eq("ready_timeout", 0, 1);
   endtask

   // Issue one opcode and follow it to its o_done.
   task automatic run_op(input int op, input bit rand_beats, input bit hold, input int hold_mode);
      int  exp_nrd = 0, exp_beats = 0, exp_nlast = 0;
      int  nrd = 0, nbeats = 0, nlast = 0, ndone = 0;
      int  last_cyc = 0, done_cyc = 0, last_val = 0;
      int  seq_err = 0, origin_err = 0, ready_seen = 0, cyc = 1;
      bit  is_sweep = 1'b0;

      wait_ready();
      case (op)
         0: begin exp_beats = 2048; exp_mode = 0; exp_counter = 2047; exp_nlast = 1; end
         1: if (col < 6) col++;
         2: if (col > 0) col--;
         3: if (row > 0) row--;
         4: if (row < 6) row++;
`ifdef SEQ_DEPTH_SCALE_EN
         5: if (ch > 8) ch = ch / 2;
         6: if (ch < 32) ch = ch * 2;
`endif
         7: begin exp_nrd = 4 * ch;  exp_mode = 1; exp_counter = exp_nrd - 1; is_sweep = 1'b1; exp_nlast = 1; end
         8: begin exp_nrd = 16 * ch; exp_mode = 2; exp_counter = exp_nrd - 1; is_sweep = 1'b1; exp_nlast = 1; end
         default: ;
      endcase

      i_op_valid = 1'b1;
      i_op_mode  = 4'(op);
      @(posedge i_clk); #1;
      if (hold) i_op_mode = 4'(hold_mode);
      else      i_op_valid = 1'b0;

      while (ndone == 0 && cyc <= 20000) begin
         if (op == 0 && nlast == 0)
            i_in_valid = rand_beats ? 1'($urandom_range(0, 1)) : cyc[0];
         else
            i_in_valid = 1'b0;
         @(negedge i_clk);
         if (o_rd_en) begin
            if (int'(o_counter) != nrd) seq_err++;
            nrd++;
         end
         if (i_in_valid && o_in_ready) begin
            if (int'(o_counter) != nbeats) seq_err++;
            nbeats++;
         end
         if (o_last) begin
            nlast++;
            last_cyc = cyc;
            last_val = int'(o_counter);
         end
         if (o_op_ready) ready_seen++;
         if (int'(o_origin) != row * 8 + col) origin_err++;
         if (o_done) begin
            ndone++;
            done_cyc = cyc;
         end
         @(posedge i_clk); #1;
         cyc++;
      end
      i_in_valid = 1'b0;
      i_op_valid = 1'b0;

      if (ndone == 0) begin
         check_eq("op_timeout", 0, 1);
         return;
      end

      check_eq("done_pulse",  32'(o_done), 0);
      check_eq("idle_ready",  32'(o_op_ready), 1);
      check_eq("rd_count",    nrd, exp_nrd);
      check_eq("beats",       nbeats, exp_beats);
      check_eq("last_count",  nlast, exp_nlast);
      check_eq("seq_index",   seq_err, 0);
      check_eq("origin_live", origin_err, 0);
      check_eq("busy_ready",  ready_seen, 0);
      check_eq("origin",      32'(o_origin), row * 8 + col);
      check_eq("depth",       32'(o_depth), depth_code(ch));
      check_eq("mode",        32'(o_mode), exp_mode);
      check_eq("counter",     32'(o_counter), exp_counter);
      if (exp_nlast != 0) check_eq("last_index", last_val, exp_counter);
      if (is_sweep) begin
         check_eq("last_cycle", last_cyc, exp_nrd);
         check_eq("done_cycle", done_cyc, exp_nrd + RD_LAT + 1);
      end else if (op == 0) begin
         check_eq("load_done_gap", done_cyc - last_cyc, 1);
      end else begin
         check_eq("done_cycle", done_cyc, 1);
      end

      $display("op=%0d hold=%0d rd=%0d beats=%0d done_cyc=%0d origin=%02h depth=%0d",
               op, hold, nrd, nbeats, done_cyc, o_origin, o_depth);
   endtask

   initial begin
      int n;
      int bad_done, bad_rd, bad_ready;

      i_rst      = 1'b1;
      i_op_valid = 1'b0;
      i_op_mode  = 4'd0;
      i_in_valid = 1'b0;

      // reset acts before any clock edge
      #3;
      check_reset_outputs("por");
      @(posedge i_clk); @(posedge i_clk); #3;
      i_rst = 1'b0;
      @(posedge i_clk); #1;

      // load with i_in_valid on every other cycle
      run_op(0, 1'b0, 1'b0, 0);

      // walk origin to row 6 / col 6, then probe the edges
      for (int i = 0; i < 6; i++) run_op(1, 1'b0, 1'b0, 0);
      for (int i = 0; i < 6; i++) run_op(4, 1'b0, 1'b0, 0);
      check_eq("origin_36", 32'(o_origin), 32'h36);
      run_op(1, 1'b0, 1'b0, 0);
      run_op(4, 1'b0, 1'b0, 0);
      check_eq("origin_36_hold", 32'(o_origin), 32'h36);
      run_op(2, 1'b0, 1'b0, 0);
      run_op(3, 1'b0, 1'b0, 0);
      check_eq("origin_2d", 32'(o_origin), 32'h2D);

      // display at depth 32
      run_op(7, 1'b0, 1'b0, 0);

      // shrink depth, conv, shrink again at the floor, grow back
      run_op(5, 1'b0, 1'b0, 0);
      run_op(5, 1'b0, 1'b0, 0);
      run_op(8, 1'b0, 1'b0, 0);
      run_op(5, 1'b0, 1'b0, 0);
      run_op(6, 1'b0, 1'b0, 0);
      run_op(6, 1'b0, 1'b0, 0);
      run_op(6, 1'b0, 1'b0, 0);

      // reset in the middle of a conv sweep
      wait_ready();
      i_op_valid = 1'b1;
      i_op_mode  = 4'd8;
      @(posedge i_clk); #1;
      i_op_valid = 1'b0;
      n = 0;
      while (o_counter != 11'd300 && n < 2000) begin
         @(posedge i_clk); #1;
         n++;
      end
      check_eq("rst_reach_300", 32'(n < 2000), 1);
      check_eq("rst_pre_rd_en", 32'(o_rd_en), 1);
      #2 i_rst = 1'b1;
      #1;
      check_reset_outputs("midrst");
      @(posedge i_clk); @(posedge i_clk); #3;
      i_rst = 1'b0;
      row = 0; col = 0; ch = 32; exp_mode = 0; exp_counter = 0;
      bad_done = 0; bad_rd = 0; bad_ready = 0;
      for (int i = 0; i < 600; i++) begin
         @(negedge i_clk);
         if (o_done)      bad_done++;
         if (o_rd_en)     bad_rd++;
         if (!o_op_ready) bad_ready++;
      end
      check_eq("post_rst_done",  bad_done, 0);
      check_eq("post_rst_rd_en", bad_rd, 0);
      check_eq("post_rst_ready", bad_ready, 0);
      check_eq("post_rst_counter", 32'(o_counter), 0);
      @(posedge i_clk); #1;

      // opcodes held on the bus while busy must be ignored
      run_op(7, 1'b0, 1'b1, 1);
      run_op(12, 1'b0, 1'b0, 0);

      // load with random beat gaps
      run_op(0, 1'b1, 1'b0, 0);

      // random opcode mix
      for (int i = 0; i < 40; i++) begin
         int op_r, hold_r;
         op_r   = int'($urandom_range(1, 15));
         hold_r = int'($urandom_range(0, 3));
         run_op(op_r, 1'b0, (hold_r == 0), int'($urandom_range(0, 15)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/addr_seq_ctrl.md
ADDR_SEQ_CTRL -- requirements
Module: addr_seq_ctrl

Interface
REQ-001 Parameter RD_LAT, default 1: SRAM read latency in cycles; legal range 1..3.
REQ-002 i_clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 i_rst  input  1  asynchronous, active-high reset.
REQ-004 i_op_valid  input  1  opcode on i_op_mode is valid.
REQ-005 i_op_mode  input  4  opcode: 0 load, 1 right, 2 left, 3 up, 4 down, 5 scale-down, 6 scale-up, 7 display, 8 conv.
REQ-006 o_op_ready  output  1  block idle and able to accept an opcode.
REQ-007 i_in_valid  input  1  one image pixel presented during load.
REQ-008 o_in_ready  output  1  load beat accepted this cycle.
REQ-009 o_counter  output  11  sweep index for the downstream address generator.
REQ-010 o_mode  output  2  address-generator mode: 0 load, 1 display, 2 conv.
REQ-011 o_origin  output  6  window origin {row[2:0], col[2:0]}.
REQ-012 o_depth  output  2  active channel depth: 0 = 8, 1 = 16, 2 = 32.
REQ-013 o_rd_en  output  1  memory access issued this cycle.
REQ-014 o_last  output  1  final access of the current sweep.
REQ-015 o_done  output  1  one-cycle pulse when the current opcode has fully completed.

Function
REQ-016 FSM states SHALL be IDLE, LOAD, ISSUE, DRAIN, DONE; o_op_ready = (state == IDLE).
REQ-017 An opcode SHALL be accepted only when i_op_valid && o_op_ready; i_op_valid is ignored in all other cycles.
REQ-018 Load: IDLE->LOAD, o_mode=0, counter=0; o_in_ready=1; counter increments on each i_in_valid beat; on the beat with counter=2047: o_last=1, then ->DONE.
REQ-019 Shift ops: origin update on the acceptance edge -> DONE. Right ignored at col=6, left at col=0, up at row=0, down at row=6.
REQ-020 Scale ops: depth steps 8<->16<->32. Scale-down at 8 and scale-up at 32 are no-ops. ->DONE.
REQ-021 Display: ISSUE with o_mode=1; counter 0..(4*depth-1), one per cycle, o_rd_en=1 each cycle, o_last on the final count; then ->DRAIN.
REQ-022 Conv: ISSUE with o_mode=2; counter 0..(16*depth-1), one per cycle, o_rd_en/o_last as for display; then ->DRAIN.
REQ-023 DRAIN SHALL last exactly RD_LAT cycles (delay line), then ->DONE; o_rd_en=0 throughout.
REQ-024 DONE: o_done=1 for one cycle, ->IDLE; next opcode acceptable the following cycle.
REQ-025 Opcodes 9..15 SHALL be no-ops that go straight to DONE.
REQ-026 o_counter, o_mode, o_origin, o_depth are registered; between sweeps they hold their last value.
REQ-027 Counter arithmetic is unsigned 11-bit; terminal count compare uses depth-derived limits, no wrap past the limit.

Reset
REQ-028 i_rst SHALL force, asynchronously and mid-operation included: state=IDLE, o_counter=0, o_mode=0, o_origin=0, o_depth=2 (32), o_rd_en=0, o_last=0, o_done=0, o_in_ready=0, delay line cleared.
REQ-029 No partial sweep or o_done SHALL resume after reset release.

Configuration
REQ-030 Macro SEQ_DEPTH_SCALE_EN defined: scale ops behave per REQ-020.
REQ-031 Macro SEQ_DEPTH_SCALE_EN undefined: o_depth is fixed at 2, opcodes 5/6 are no-ops (DONE only), depth registers are absent.

Structure
REQ-032 Package seq_pkg SHALL hold the opcode enum, mode codes (0/1/2), depth codes, LOAD_LAST=2047 and ORIGIN_MAX=6.
REQ-033 One sub-module, seq_lat_pipe: RD_LAT-deep shift register producing DRAIN completion from o_last.

Verification
REQ-034 Load 2048 beats with i_in_valid toggling every other cycle -> counter advances only on beats, o_last at 2047, o_done one cycle later.
REQ-035 Origin 0x36 (row 6, col 6): right, down -> origin unchanged; left, up -> 0x2D; each op gives one o_done.
REQ-036 Depth 32, display -> 128 o_rd_en cycles (counter 0..127), o_done RD_LAT+1 cycles after o_last.
REQ-037 Scale-down twice, then conv -> depth=0 and 128 issue cycles; a third scale-down leaves depth 0.
REQ-038 i_rst asserted at counter=300 of a conv -> all outputs at reset values immediately; o_op_ready high after release; no o_done.
REQ-039 i_op_valid held high during ISSUE with opcode 1 -> origin unchanged until DONE->IDLE; opcode 12 -> o_done only.
